// File: rtl/static_south_axi_responder.sv
// rtl/static_south_axi_responder.sv - AXI4 slave backed by an on-chip DEPTH_WORDS x 512-bit memory, one transaction at a time.
// Optional beat counters are enabled by defining STATIC_SOUTH_RESP_BEAT_CNT_EN.
module static_south_axi_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          ADDR_W      = 64,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic              CLK_IN_250,
    input  logic              AXI_RESET,
    input  logic [ADDR_W-1:0] S_AXI_SOUTH_awaddr,
    input  logic [7:0]        S_AXI_SOUTH_awlen,
    input  logic [2:0]        S_AXI_SOUTH_awsize,
    input  logic [1:0]        S_AXI_SOUTH_awburst,
    input  logic              S_AXI_SOUTH_awvalid,
    output logic              S_AXI_SOUTH_awready,
    input  logic [511:0]      S_AXI_SOUTH_wdata,
    input  logic [63:0]       S_AXI_SOUTH_wstrb,
    input  logic              S_AXI_SOUTH_wlast,
    input  logic              S_AXI_SOUTH_wvalid,
    output logic              S_AXI_SOUTH_wready,
    output logic [1:0]        S_AXI_SOUTH_bresp,
    output logic              S_AXI_SOUTH_bvalid,
    input  logic              S_AXI_SOUTH_bready,
    input  logic [ADDR_W-1:0] S_AXI_SOUTH_araddr,
    input  logic [7:0]        S_AXI_SOUTH_arlen,
    input  logic [2:0]        S_AXI_SOUTH_arsize,
    input  logic [1:0]        S_AXI_SOUTH_arburst,
    input  logic              S_AXI_SOUTH_arvalid,
    output logic              S_AXI_SOUTH_arready,
    output logic [511:0]      S_AXI_SOUTH_rdata,
    output logic [1:0]        S_AXI_SOUTH_rresp,
    output logic              S_AXI_SOUTH_rlast,
    output logic              S_AXI_SOUTH_rvalid,
    input  logic              S_AXI_SOUTH_rready
`ifdef STATIC_SOUTH_RESP_BEAT_CNT_EN
    ,
    output logic [31:0]       wr_beat_cnt,
    output logic [31:0]       rd_beat_cnt
`endif
);
    localparam int WORD_W  = $clog2(DEPTH_WORDS);
    localparam int WIN_LSB = 6 + WORD_W;

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ISSUE, RD_DATA} state_t;

    state_t              state_q, state_d;
    logic                pref_wr_q, pref_wr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                fixed_q, fixed_d;
    logic                err_q, err_d;
    logic                last_bad_q, last_bad_d;
    logic [511:0]        rdata_q;
    logic                mem_we, mem_re;
    logic [511:0]        mem [DEPTH_WORDS];

    logic                sel_aw, sel_ar;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [2:0]          cmd_size;
    logic [1:0]          cmd_burst;
    logic                cmd_err;
    logic                unused_addr_lsbs;

    // Round-robin only matters when both valids are high; pref_wr_q names the favoured channel.
    assign sel_aw    = S_AXI_SOUTH_awvalid && (!S_AXI_SOUTH_arvalid || pref_wr_q);
    assign sel_ar    = S_AXI_SOUTH_arvalid && !sel_aw;
    assign cmd_addr  = sel_aw ? S_AXI_SOUTH_awaddr  : S_AXI_SOUTH_araddr;
    assign cmd_size  = sel_aw ? S_AXI_SOUTH_awsize  : S_AXI_SOUTH_arsize;
    assign cmd_burst = sel_aw ? S_AXI_SOUTH_awburst : S_AXI_SOUTH_arburst;
    assign cmd_err   = (cmd_size != 3'd6) || (cmd_burst == 2'b10) ||
                       (cmd_addr[ADDR_W-1:WIN_LSB] != BASE_ADDR[ADDR_W-1:WIN_LSB]);
    assign unused_addr_lsbs = ^cmd_addr[5:0];

    always_comb begin
        state_d    = state_q;
        pref_wr_d  = pref_wr_q;
        word_d     = word_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        fixed_d    = fixed_q;
        err_d      = err_q;
        last_bad_d = last_bad_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        S_AXI_SOUTH_awready = 1'b0;
        S_AXI_SOUTH_arready = 1'b0;
        S_AXI_SOUTH_wready  = 1'b0;
        S_AXI_SOUTH_bvalid  = 1'b0;
        S_AXI_SOUTH_bresp   = 2'b00;
        S_AXI_SOUTH_rvalid  = 1'b0;
        S_AXI_SOUTH_rdata   = '0;
        S_AXI_SOUTH_rresp   = 2'b00;
        S_AXI_SOUTH_rlast   = 1'b0;
        // Outputs stay quiet during the reset cycle itself, whatever state we are leaving.
        if (!AXI_RESET) begin
            case (state_q)
                IDLE: begin
                    S_AXI_SOUTH_awready = sel_aw;
                    S_AXI_SOUTH_arready = sel_ar;
                    if (sel_aw || sel_ar) begin
                        word_d     = cmd_addr[6 +: WORD_W];
                        len_d      = sel_aw ? S_AXI_SOUTH_awlen : S_AXI_SOUTH_arlen;
                        fixed_d    = (cmd_burst == 2'b00);
                        err_d      = cmd_err;
                        cnt_d      = 8'd0;
                        last_bad_d = 1'b0;
                        pref_wr_d  = sel_ar;
                        state_d    = sel_aw ? WR : RD_ISSUE;
                    end
                end
                WR: begin
                    S_AXI_SOUTH_wready = 1'b1;
                    if (S_AXI_SOUTH_wvalid) begin
                        mem_we = !err_q;
                        if (S_AXI_SOUTH_wlast != (cnt_q == len_q)) begin
                            last_bad_d = 1'b1;
                        end
                        if (cnt_q == len_q) begin
                            state_d = WRESP;
                        end else begin
                            cnt_d  = cnt_q + 8'd1;
                            word_d = fixed_q ? word_q : word_q + 1'b1;
                        end
                    end
                end
                WRESP: begin
                    S_AXI_SOUTH_bvalid = 1'b1;
                    S_AXI_SOUTH_bresp  = (err_q || last_bad_q) ? 2'b10 : 2'b00;
                    if (S_AXI_SOUTH_bready) begin
                        state_d = IDLE;
                    end
                end
                RD_ISSUE: begin
                    mem_re  = 1'b1;
                    state_d = RD_DATA;
                end
                RD_DATA: begin
                    S_AXI_SOUTH_rvalid = 1'b1;
                    S_AXI_SOUTH_rdata  = rdata_q;
                    S_AXI_SOUTH_rresp  = err_q ? 2'b10 : 2'b00;
                    S_AXI_SOUTH_rlast  = (cnt_q == len_q);
                    if (S_AXI_SOUTH_rready) begin
                        if (cnt_q == len_q) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d   = cnt_q + 8'd1;
                            word_d  = fixed_q ? word_q : word_q + 1'b1;
                            state_d = RD_ISSUE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_IN_250) begin
        if (AXI_RESET) begin
            state_q    <= IDLE;
            pref_wr_q  <= 1'b1;
            word_q     <= '0;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            fixed_q    <= 1'b0;
            err_q      <= 1'b0;
            last_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pref_wr_q  <= pref_wr_d;
            word_q     <= word_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            fixed_q    <= fixed_d;
            err_q      <= err_d;
            last_bad_q <= last_bad_d;
        end
    end

    // Memory is deliberately outside the reset domain so a partial burst keeps its beats.
    always_ff @(posedge CLK_IN_250) begin
        if (mem_we) begin
            for (int b = 0; b < 64; b++) begin
                if (S_AXI_SOUTH_wstrb[b]) begin
                    mem[word_q][b*8 +: 8] <= S_AXI_SOUTH_wdata[b*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            rdata_q <= err_q ? '0 : mem[word_q];
        end
    end

`ifdef STATIC_SOUTH_RESP_BEAT_CNT_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge CLK_IN_250) begin
        if (AXI_RESET) begin
            wr_cnt_q <= 32'd0;
            rd_cnt_q <= 32'd0;
        end else begin
            if (S_AXI_SOUTH_wvalid && S_AXI_SOUTH_wready) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (S_AXI_SOUTH_rvalid && S_AXI_SOUTH_rready) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_beat_cnt = wr_cnt_q;
    assign rd_beat_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_static_south_axi_responder.sv
// tb/tb_static_south_axi_responder.sv - directed and random AXI traffic against a byte-level memory model.
module tb_static_south_axi_responder;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h0000_0000_0004_0000;
    localparam int          TMO   = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, awready, arvalid, arready;
    logic [511:0] wdata, rdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, rlast, rvalid, rready;
`ifdef STATIC_SOUTH_RESP_BEAT_CNT_EN
    logic [31:0]  wr_beat_cnt, rd_beat_cnt;
`endif

    logic [511:0] ref_mem [DEPTH];
    bit           pref_wr;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    static_south_axi_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(64), .BASE_ADDR(BASE)) dut (
        .CLK_IN_250(clk), .AXI_RESET(rst),
        .S_AXI_SOUTH_awaddr(awaddr), .S_AXI_SOUTH_awlen(awlen), .S_AXI_SOUTH_awsize(awsize),
        .S_AXI_SOUTH_awburst(awburst), .S_AXI_SOUTH_awvalid(awvalid), .S_AXI_SOUTH_awready(awready),
        .S_AXI_SOUTH_wdata(wdata), .S_AXI_SOUTH_wstrb(wstrb), .S_AXI_SOUTH_wlast(wlast),
        .S_AXI_SOUTH_wvalid(wvalid), .S_AXI_SOUTH_wready(wready),
        .S_AXI_SOUTH_bresp(bresp), .S_AXI_SOUTH_bvalid(bvalid), .S_AXI_SOUTH_bready(bready),
        .S_AXI_SOUTH_araddr(araddr), .S_AXI_SOUTH_arlen(arlen), .S_AXI_SOUTH_arsize(arsize),
        .S_AXI_SOUTH_arburst(arburst), .S_AXI_SOUTH_arvalid(arvalid), .S_AXI_SOUTH_arready(arready),
        .S_AXI_SOUTH_rdata(rdata), .S_AXI_SOUTH_rresp(rresp), .S_AXI_SOUTH_rlast(rlast),
        .S_AXI_SOUTH_rvalid(rvalid), .S_AXI_SOUTH_rready(rready)
`ifdef STATIC_SOUTH_RESP_BEAT_CNT_EN
        , .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic bit is_err(input logic [63:0] a, input logic [2:0] sz, input logic [1:0] bt);
        return (sz != 3'd6) || (bt == 2'b10) || (a < BASE) || (a >= BASE + 64'(DEPTH * 64));
    endfunction

    function automatic int beat_word(input logic [63:0] a, input logic [1:0] bt, input int beat);
        int w0;
        w0 = int'((a - BASE) / 64);
        return (bt == 2'b00) ? w0 : (w0 + beat) % DEPTH;
    endfunction

    function automatic logic [63:0] waddr(input int w);
        return BASE + 64'(w) * 64;
    endfunction

    task automatic send_aw(input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt);
        int n = 0;
        awaddr = a; awlen = 8'(len); awsize = sz; awburst = bt; awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!awready && n < TMO);
        chk("aw_ready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        pref_wr = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt);
        int n = 0;
        araddr = a; arlen = 8'(len); arsize = sz; arburst = bt; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < TMO);
        chk("ar_ready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        pref_wr = 1'b1;
    endtask

    // mode 0: random data, full strobe; 1: random data and strobe; 2: fdata/fstrb
    task automatic send_w(input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt,
                          input int mode, input logic [511:0] fdata, input logic [63:0] fstrb,
                          input int bad_beat, input int abort_beat);
        bit err;
        err = is_err(a, sz, bt);
        for (int b = 0; b <= len; b++) begin
            logic [511:0] d;
            logic [63:0]  s;
            int n, w;
            d = (mode == 2) ? fdata : rnd512();
            s = (mode == 0) ? '1 : (mode == 1) ? {$urandom(), $urandom()} : fstrb;
            wdata = d; wstrb = s; wlast = ((b == len) != (b == bad_beat)); wvalid = 1'b1;
            if (b == abort_beat) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < TMO);
            chk("w_ready", wready, 1'b1);
            @(posedge clk); #1;
            if (!err) begin
                w = beat_word(a, bt, b);
                for (int y = 0; y < 64; y++) if (s[y]) ref_mem[w][y*8 +: 8] = d[y*8 +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b(input logic [1:0] exp);
        int n = 0;
        bready = 1'b1;
        do begin @(negedge clk); n++; end while (!bvalid && n < TMO);
        chk("b_valid", bvalid, 1'b1);
        chk("b_resp", bresp, exp);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic get_r(input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt,
                         input int stall_beat);
        bit err;
        err = is_err(a, sz, bt);
        for (int b = 0; b <= len; b++) begin
            logic [511:0] exp_d;
            int n = 0;
            exp_d = err ? '0 : ref_mem[beat_word(a, bt, b)];
            rready = (b != stall_beat);
            do begin @(negedge clk); n++; end while (!rvalid && n < TMO);
            chk("r_valid", rvalid, 1'b1);
            chk("r_data", rdata, exp_d);
            chk("r_resp", rresp, err ? 2'b10 : 2'b00);
            chk("r_last", rlast, (b == len));
            if (b == stall_beat) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("r_hold_valid", rvalid, 1'b1);
                    chk("r_hold_data", rdata, exp_d);
                end
                rready = 1'b1;
            end
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt,
                            input int mode, input logic [511:0] fdata, input logic [63:0] fstrb, input int bad);
        send_aw(a, len, sz, bt);
        send_w(a, len, sz, bt, mode, fdata, fstrb, bad, -1);
        get_b((is_err(a, sz, bt) || (bad >= 0 && bad <= len)) ? 2'b10 : 2'b00);
    endtask

    task automatic do_read(input logic [63:0] a, input int len, input logic [2:0] sz, input logic [1:0] bt,
                           input int stall_beat);
        send_ar(a, len, sz, bt);
        get_r(a, len, sz, bt, stall_beat);
    endtask

    initial begin
        logic [511:0] pat_a;
        logic [511:0] ones;
        bit exp_w;
        pat_a = {16{32'hA5A5_5A5A}};
        ones  = '1;
        rst = 1'b1; pref_wr = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rlast", rlast, 1'b0);
        @(posedge clk); #1;

        do_write(waddr(200), 15, 3'd6, 2'b01, 0, '0, '0, -1);
        do_write(BASE + 64'h40, 0, 3'd6, 2'b01, 2, pat_a, '1, -1);
        do_read(BASE + 64'h40, 0, 3'd6, 2'b01, -1);
        do_write(waddr(DEPTH - 2), 3, 3'd6, 2'b01, 0, '0, '0, -1);
        do_read(waddr(DEPTH - 2), 3, 3'd6, 2'b01, -1);
        do_write(BASE + 64'h80, 0, 3'd6, 2'b01, 2, ones, '1, -1);
        do_write(BASE + 64'h80, 0, 3'd6, 2'b01, 2, '0, 64'h0F, -1);
        do_read(BASE + 64'h80, 0, 3'd6, 2'b01, -1);
        do_write(waddr(205), 0, 3'd5, 2'b01, 0, '0, '0, -1);
        do_read(waddr(205), 0, 3'd6, 2'b01, -1);
        do_read(BASE + 64'(DEPTH * 64), 1, 3'd6, 2'b01, -1);
        do_write(waddr(207), 1, 3'd6, 2'b10, 0, '0, '0, -1);
        do_read(waddr(207), 1, 3'd6, 2'b01, -1);
        do_write(waddr(209), 2, 3'd6, 2'b01, 0, '0, '0, 0);
        do_read(waddr(209), 2, 3'd6, 2'b01, 1);

        // Both channels valid together: the served channel should alternate.
        awaddr = waddr(211); awlen = 8'd0; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b1;
        araddr = waddr(203); arlen = 8'd1; arsize = 3'd6; arburst = 2'b01; arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_w = awvalid && (!arvalid || pref_wr);
            chk("arb_awready", awready, exp_w);
            chk("arb_arready", arready, !exp_w && arvalid);
            @(posedge clk); #1;
            if (exp_w) begin
                awvalid = 1'b0; pref_wr = 1'b0;
                send_w(waddr(211), 0, 3'd6, 2'b01, 0, '0, '0, -1, -1);
                get_b(2'b00);
                if (k < 2) awvalid = 1'b1;
            end else begin
                arvalid = 1'b0; pref_wr = 1'b1;
                get_r(waddr(203), 1, 3'd6, 2'b01, -1);
                if (k < 2) arvalid = 1'b1;
            end
        end
        do_read(waddr(211), 0, 3'd6, 2'b01, -1);

        for (int i = 0; i < 8; i++) begin
            int w, l;
            logic [1:0] bt;
            w  = 200 + $urandom_range(0, 12);
            l  = $urandom_range(0, 3);
            bt = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            do_write(waddr(w), l, 3'd6, bt, 1, '0, '0, -1);
            w  = 200 + $urandom_range(0, 12);
            l  = $urandom_range(0, 3);
            bt = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            do_read(waddr(w), l, 3'd6, bt, -1);
        end

        send_aw(waddr(200), 7, 3'd6, 2'b01);
        send_w(waddr(200), 7, 3'd6, 2'b01, 0, '0, '0, -1, 2);
        pref_wr = 1'b1;
        @(negedge clk);
        chk("abort_awready", awready, 1'b0);
        chk("abort_arready", arready, 1'b0);
        chk("abort_wready", wready, 1'b0);
        chk("abort_bvalid", bvalid, 1'b0);
        chk("abort_rvalid", rvalid, 1'b0);
        @(posedge clk); #1;
        do_write(waddr(300), 0, 3'd6, 2'b01, 0, '0, '0, -1);
        do_read(waddr(300), 0, 3'd6, 2'b01, -1);
        do_read(waddr(200), 2, 3'd6, 2'b01, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
